// File: rtl/axi_adapter_arb_pkg.sv
// Shared types and the round-robin helper for the AXI adapter arbiter.
package axi_adapter_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitRsp
  } arb_state_e;

  typedef struct packed {
    logic [63:0] addr;
    logic        we;
    logic        single;
    logic [1:0]  size;
  } req_bundle_t;

  // First set bit of req at or after ptr, wrapping modulo n (n <= 8); returns ptr if none set.
  function automatic logic [2:0] rr_next(input logic [2:0] ptr, input logic [7:0] req,
                                         input int unsigned n);
    logic [2:0]  win;
    int unsigned idx;
    win = ptr;
    for (int k = 7; k >= 0; k--) begin
      if (k < int'(n)) begin
        idx = (32'(ptr) + 32'(k)) % n;
        if (req[idx[2:0]]) win = idx[2:0];
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/axi_adapter_arb_if.sv
// Arbiter <-> AXI adapter request/response bundle.
interface axi_adapter_arb_if #(
  parameter int unsigned DATA_WIDTH     = 256,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4
);
  logic                      adp_req_o;
  logic                      adp_single_o;
  logic                      adp_we_o;
  logic [63:0]               adp_addr_o;
  logic [DATA_WIDTH-1:0]     adp_wdata_o;
  logic [DATA_WIDTH/8-1:0]   adp_be_o;
  logic [1:0]                adp_size_o;
  logic [AXI_ID_WIDTH-1:0]   adp_id_o;
  logic                      adp_gnt_i;
  logic                      adp_valid_i;
  logic                      adp_cw_valid_i;
  logic                      adp_busy_i;
  logic [DATA_WIDTH-1:0]     adp_rdata_i;
  logic [AXI_DATA_WIDTH-1:0] adp_cw_i;
  logic [AXI_ID_WIDTH-1:0]   adp_id_i;

  modport arb (
    output adp_req_o, adp_single_o, adp_we_o, adp_addr_o, adp_wdata_o, adp_be_o, adp_size_o,
           adp_id_o,
    input  adp_gnt_i, adp_valid_i, adp_cw_valid_i, adp_busy_i, adp_rdata_i, adp_cw_i, adp_id_i
  );

  modport adp (
    input  adp_req_o, adp_single_o, adp_we_o, adp_addr_o, adp_wdata_o, adp_be_o, adp_size_o,
           adp_id_o,
    output adp_gnt_i, adp_valid_i, adp_cw_valid_i, adp_busy_i, adp_rdata_i, adp_cw_i, adp_id_i
  );
endinterface

// File: rtl/axi_adapter_arb_rr_pick.sv
// Combinational round-robin picker: request vector + pointer -> one-hot winner and index.
module axi_adapter_arb_rr_pick
  import axi_adapter_arb_pkg::*;
#(
  parameter int unsigned N    = 3,
  parameter int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    onehot_o,
  output logic [IdxW-1:0] idx_o
);

  always_comb begin
    idx_o    = IdxW'(rr_next(3'(ptr_i), 8'(req_i), N));
    onehot_o = (|req_i) ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/axi_adapter_arb.sv
// Round-robin sharing of one single-outstanding AXI adapter among NUM_REQ requesters.
// Optional response watchdog: define AXI_ADAPTER_ARB_WDOG_EN.
module axi_adapter_arb
  import axi_adapter_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned DATA_WIDTH     = 256,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned WDOG_CYCLES    = 1024
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NUM_REQ-1:0]                   req_i,
  input  logic [NUM_REQ-1:0]                   single_i,
  input  logic [NUM_REQ-1:0]                   we_i,
  input  logic [NUM_REQ-1:0][63:0]             addr_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   wdata_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0] be_i,
  input  logic [NUM_REQ-1:0][1:0]              size_i,
  output logic [NUM_REQ-1:0]                   gnt_o,
  output logic [NUM_REQ-1:0]                   valid_o,
  output logic [DATA_WIDTH-1:0]                rdata_o,
  output logic [AXI_DATA_WIDTH-1:0]            cw_o,
  output logic [NUM_REQ-1:0]                   cw_valid_o,
  axi_adapter_arb_if.arb                       adp,
  output logic                                 wdog_err_o
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_num_req_chk
    $error("NUM_REQ must be 2..8");
  end
  if (AXI_ID_WIDTH < IdxW) begin : g_id_chk
    $error("AXI_ID_WIDTH too narrow to carry the owner index");
  end
  if (WDOG_CYCLES < 2) begin : g_wdog_chk
    $error("WDOG_CYCLES must be at least 2");
  end

  arb_state_e        state_q, state_d;
  logic [IdxW-1:0]   owner_q, owner_d, rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IdxW-1:0]   pick_idx;
  req_bundle_t       sel;

  axi_adapter_arb_rr_pick #(
    .N    (NUM_REQ),
    .IdxW (IdxW)
  ) u_rr_pick (
    .req_i    (req_i),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx)
  );

  always_comb begin
    sel.addr   = addr_i[owner_q];
    sel.we     = we_i[owner_q];
    sel.single = single_i[owner_q];
    sel.size   = size_i[owner_q];
  end

  assign rdata_o = adp.adp_rdata_i;
  assign cw_o    = adp.adp_cw_i;

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    rr_ptr_d         = rr_ptr_q;
    gnt_o            = '0;
    valid_o          = '0;
    cw_valid_o       = '0;
    adp.adp_req_o    = 1'b0;
    adp.adp_single_o = 1'b0;
    adp.adp_we_o     = 1'b0;
    adp.adp_addr_o   = '0;
    adp.adp_wdata_o  = '0;
    adp.adp_be_o     = '0;
    adp.adp_size_o   = '0;
    adp.adp_id_o     = '0;
    unique case (state_q)
      StIdle: begin
        if (|pick_onehot && !adp.adp_busy_i) begin
          owner_d = pick_idx;
          state_d = StIssue;
        end
      end
      StIssue: begin
        adp.adp_single_o = sel.single;
        adp.adp_we_o     = sel.we;
        adp.adp_addr_o   = sel.addr;
        adp.adp_size_o   = sel.size;
        adp.adp_wdata_o  = wdata_i[owner_q];
        adp.adp_be_o     = be_i[owner_q];
        adp.adp_id_o     = AXI_ID_WIDTH'(owner_q);
        // Owner withdrew before the adapter accepted: abort without moving the pointer.
        if (!req_i[owner_q]) begin
          state_d = StIdle;
        end else begin
          adp.adp_req_o  = 1'b1;
          gnt_o[owner_q] = adp.adp_gnt_i;
          if (adp.adp_gnt_i) begin
            rr_ptr_d = (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
            state_d  = StWaitRsp;
          end
        end
      end
      StWaitRsp: begin
        cw_valid_o[owner_q] = adp.adp_cw_valid_i;
        if (adp.adp_valid_i) begin
          valid_o[owner_q] = 1'b1;
          state_d          = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef AXI_ADAPTER_ARB_WDOG_EN
  localparam int unsigned CntW = $clog2(WDOG_CYCLES) + 1;

  logic [CntW-1:0] wdog_cnt_q;
  logic            wdog_err_q;
  logic            wdog_hit;

  assign wdog_hit   = (state_q == StWaitRsp) && (wdog_cnt_q == CntW'(WDOG_CYCLES - 1));
  assign wdog_err_o = wdog_err_q | wdog_hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      if (state_q != StWaitRsp) begin
        wdog_cnt_q <= '0;
      end else if (!wdog_hit) begin
        wdog_cnt_q <= wdog_cnt_q + 1'b1;
      end
      if (wdog_hit) wdog_err_q <= 1'b1;
    end
  end
`else
  assign wdog_err_o = 1'b0;
`endif

  a_rsp_id: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == StWaitRsp && adp.adp_valid_i) |-> adp.adp_id_i == AXI_ID_WIDTH'(owner_q));
  a_rsp_stray: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q != StWaitRsp) |-> !(adp.adp_valid_i || adp.adp_cw_valid_i));

endmodule

// File: doc/axi_adapter_arb.md
Name: axi_adapter_arb

Overview:
- Shares one single-outstanding AXI adapter (the cache-line/single-beat AXI master) between NUM_REQ cache-side requesters, e.g. icache refill, dcache refill/writeback, uncached bypass.
- Round-robin arbitration. The grant is locked from request issue until the adapter returns valid.
- Responses and critical words are routed back to the owning requester only.
- Sits between the cache subsystem and the adapter; the AXI ID carries the owner index.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- DATA_WIDTH, 256, cache-line width in bits.
- AXI_DATA_WIDTH, 64, AXI beat width; BEATS = DATA_WIDTH/AXI_DATA_WIDTH.
- AXI_ID_WIDTH, 4, adapter ID width; must be >= $clog2(NUM_REQ) (elaboration assertion).
- WDOG_CYCLES, 1024, response timeout; used only with the optional feature.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  NUM_REQ  per-requester request
- single_i  in  NUM_REQ  1 = single-beat request, 0 = cache-line request
- we_i  in  NUM_REQ  write enable
- addr_i  in  NUM_REQ x 64  address
- wdata_i  in  NUM_REQ x DATA_WIDTH  write line
- be_i  in  NUM_REQ x DATA_WIDTH/8  byte enables
- size_i  in  NUM_REQ x 2  log2 of access bytes
- gnt_o  out  NUM_REQ  request accepted
- valid_o  out  NUM_REQ  response valid
- rdata_o  out  DATA_WIDTH  read line; broadcast, qualified by valid_o
- cw_o  out  AXI_DATA_WIDTH  critical word; broadcast
- cw_valid_o  out  NUM_REQ  critical word valid
- adp_req_o, adp_single_o, adp_we_o  out  1  to adapter
- adp_addr_o  out  64  to adapter
- adp_wdata_o, adp_be_o, adp_size_o  out  as above  to adapter
- adp_id_o  out  AXI_ID_WIDTH  to adapter
- adp_gnt_i, adp_valid_i, adp_cw_valid_i, adp_busy_i  in  1  from adapter
- adp_rdata_i  in  DATA_WIDTH  from adapter
- adp_cw_i  in  AXI_DATA_WIDTH  from adapter
- adp_id_i  in  AXI_ID_WIDTH  from adapter
- wdog_err_o  out  1  optional-feature status; tied 0 when the feature is compiled out

Behaviour:
- Reset (async, mid-operation included):
  - state=IDLE, owner_q=0, rr_ptr_q=0.
  - All outputs 0; the rdata_o/cw_o pass-throughs are don't-care.
  - An in-flight adapter transaction is abandoned; the adapter is reset by the same rst_ni.
- States: IDLE, ISSUE, WAIT_RSP.
- IDLE:
  - If any req_i and !adp_busy_i: winner = first set req_i at or after rr_ptr_q, wrapping modulo NUM_REQ.
  - Register owner_q=winner, go to ISSUE. Winner latency: 1 cycle. No adapter outputs in IDLE.
- ISSUE:
  - adp_req_o=1. Mux the owner's single/we/addr/wdata/be/size onto adp_*.
  - adp_id_o = owner_q, zero-extended.
  - gnt_o[owner_q] = adp_gnt_i (combinational).
  - On adp_gnt_i: rr_ptr_q = (owner_q+1) mod NUM_REQ (wrap at NUM_REQ-1 -> 0); go to WAIT_RSP.
  - If req_i[owner_q] drops before the grant: adp_req_o=0 that cycle, return to IDLE, no pointer update (abort). Requesters must otherwise hold request fields stable until gnt.
- WAIT_RSP:
  - adp_req_o=0.
  - cw_valid_o[owner_q] = adp_cw_valid_i.
  - On adp_valid_i: valid_o[owner_q]=1 for exactly that cycle; go to IDLE.
  - Assertion: adp_id_i == owner_q when adp_valid_i.
- Other requesters' gnt_o, valid_o and cw_valid_o stay 0 at all times.
- Minimum turnaround back-to-back: IDLE→ISSUE→(gnt)WAIT_RSP→(valid)IDLE, so a new arbitration occurs the cycle after valid.
- Simultaneous requests: exactly one winner per arbitration. A requester waits at most NUM_REQ-1 transactions.
- adp_valid_i or adp_cw_valid_i outside WAIT_RSP: ignored; assertion flags it.

Optional Feature:
- Macro: AXI_ADAPTER_ARB_WDOG_EN.
- Defined:
  - A counter clears on entering WAIT_RSP and increments each cycle there.
  - When it reaches WDOG_CYCLES-1, wdog_err_o sets. It is sticky until reset.
  - The FSM is not altered.
- Undefined: no counter; wdog_err_o tied 0.

Decomposition:
- Package axi_adapter_arb_pkg: state enum (arb_state_e), requester bundle struct (addr/we/single/size), function rr_next(ptr, req) returning the winner index.
- Sub-module axi_adapter_arb_rr_pick: combinational round-robin picker (req vector, pointer → one-hot winner + index). Reused by other arbiters.

Test Plan:
- Single requester: req_i=3'b010, read line, addr=0x8000_0040; adapter gnt after 2 cycles, valid after 6.
  - Expect gnt_o=010 once, adp_id_o=1, valid_o=010 one cycle, rdata_o routed, rr_ptr→2.
- All three request continuously, 9 transactions.
  - Expect grant order 0,1,2,0,1,2,0,1,2; no requester granted twice in a row.
- Critical word: owner 2 line read, adp_cw_valid_i pulses in WAIT_RSP.
  - Expect cw_valid_o=100 only; cw_o equals adp_cw_i.
- Abort: requester 0 drops req in ISSUE before gnt with requester 1 pending.
  - Expect no gnt_o, return to IDLE, next owner 0 if it re-requests, else 1.
- Reset asserted in WAIT_RSP.
  - Expect all outputs 0 immediately (async); after release, arbitration restarts from requester 0.
- With AXI_ADAPTER_ARB_WDOG_EN, WDOG_CYCLES=16, adapter never returns valid.
  - Expect wdog_err_o=1 at cycle 15 of WAIT_RSP, held; without the macro it stays 0.
